// File: rtl/uart_pkg.sv
// Shared definitions for the board UART receive/transmit pair.
package uart_pkg;

  localparam int UART_CLK_DIV_DEFAULT = 217;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_module_if.sv
// Byte holding-register handshake between the UART receiver and its consumer.
interface uart_rx_module_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_out;
  logic                      valid;
  logic                      ready;
  logic                      busy;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    output data_out,
    output valid,
    output busy,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  busy,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-stage synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; only r_sync is safe to use downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for rx_s low
// START | half a bit into the start bit; re-check to reject glitches
// DATA  | sampling the 8 data bits mid-bit, LSB first
// STOP  | sampling the stop bit; high delivers the byte, low is a framing error
// BREAK | line held low after a framing error; wait for it to go high
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  uart_rx_module_if.master  rx_if
);

  localparam int                          HALF      = CLK_DIV / 2;
  localparam logic [15:0]                 HALF_LOAD = 16'(HALF - 1);
  localparam logic [15:0]                 BIT_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [2:0]                  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                       w_rx_s;
  uart_rx_state_t             r_state;
  logic [15:0]                r_clk_cnt;
  logic [2:0]                 r_bit_cnt;
  logic [UART_DATA_BITS-1:0]  r_shift;
  logic [UART_DATA_BITS-1:0]  r_data;
  logic                       r_valid;
  logic                       r_frame_err;
  logic                       r_overrun;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  // Frame sequencing, bit timing and the holding register, all in one process.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Consumer handshake; a byte arriving in the same cycle overrides this below.
      if (r_valid && rx_if.ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state   <= START;
            r_clk_cnt <= HALF_LOAD;
          end
        end

        START: begin
          if (r_clk_cnt == 16'd0) begin
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_clk_cnt <= BIT_LOAD;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end

        DATA: begin
          if (r_clk_cnt == 16'd0) begin
            r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            r_clk_cnt <= BIT_LOAD;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end

        STOP: begin
          if (r_clk_cnt == 16'd0) begin
            if (w_rx_s) begin
              // Newest byte wins; flag the loss if the old one was never taken.
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_overrun <= r_valid && !rx_if.ready;
              r_state   <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end

        BREAK: begin
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.data_out  = r_data;
  assign rx_if.valid     = r_valid;
  assign rx_if.busy      = (r_state != IDLE);
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_module.sv
// Bench for uart_rx_module at CLK_DIV=16 with an ideal 16-cycle-per-bit rx driver.
module tb_uart_rx_module;

  localparam int DIV       = 16;
  localparam int HALF      = DIV / 2;
  localparam int STOP_EDGE = 2 + HALF + 9 * DIV;

  logic clk;
  logic reset_n;
  logic rx;
  int   cyc;
  int   n_cmp;
  int   n_err;

  uart_rx_module_if u_if ();

  uart_rx_module #(
    .CLK_DIV (DIV)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_if   (u_if)
  );

  // Expected events keyed by clock edge number.
  logic [7:0] ev_valid [int];
  bit         ev_ferr  [int];
  bit         busy_on  [int];
  bit         busy_off [int];

  // Reference view of the outputs.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_busy;
  logic       m_ferr;
  logic       m_ovr;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_events();
    ev_valid.delete();
    ev_ferr.delete();
    busy_on.delete();
    busy_off.delete();
  endtask

  // Full frame; leaves rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    int e0;
    e0 = cyc + 1;
    busy_on[e0 + 2] = 1'b1;
    if (stop_ok) begin
      ev_valid[e0 + STOP_EDGE] = b;
      busy_off[e0 + STOP_EDGE] = 1'b1;
    end else begin
      ev_ferr[e0 + STOP_EDGE] = 1'b1;
    end
    rx = 1'b0;
    ticks(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(DIV);
    end
    rx = stop_ok;
    ticks(DIV);
  endtask

  // Release a held-low line; receiver leaves BREAK two edges after the capture.
  task automatic release_line();
    busy_off[cyc + 3] = 1'b1;
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    int e0;
    e0 = cyc + 1;
    busy_on[e0 + 2]       = 1'b1;
    busy_off[e0 + 2 + HALF] = 1'b1;
    rx = 1'b0;
    ticks(len);
    rx = 1'b1;
    ticks(20);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: advances at every active edge.
  initial begin
    logic v_old;
    cyc = 0;
    m_valid = 1'b0; m_data = 8'h00; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_valid = 1'b0; m_data = 8'h00; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end else begin
        v_old  = m_valid;
        m_ferr = ev_ferr.exists(cyc);
        m_ovr  = 1'b0;
        if (v_old && u_if.ready) m_valid = 1'b0;
        if (ev_valid.exists(cyc)) begin
          m_data  = ev_valid[cyc];
          m_valid = 1'b1;
          m_ovr   = v_old && !u_if.ready;
        end
        if (busy_on.exists(cyc))  m_busy = 1'b1;
        if (busy_off.exists(cyc)) m_busy = 1'b0;
      end
    end
  end

  // Compare every output on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("busy",      8'(u_if.busy),      8'(m_busy));
      chk("valid",     8'(u_if.valid),     8'(m_valid));
      chk("data_out",  u_if.data_out,      m_data);
      chk("frame_err", 8'(u_if.frame_err), 8'(m_ferr));
      chk("overrun",   8'(u_if.overrun),   8'(m_ovr));
    end
  end

  initial begin
    bit   done;
    int   e0;
    logic [7:0] b;
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    rx = 1'b1;
    u_if.ready = 1'b0;
    @(posedge clk);
    #2;
    ticks(3);
    reset_n = 1'b1;
    ticks(5);

    // Single byte, consumer not ready, then a one-cycle ready.
    send_frame(8'h55, 1'b1);
    ticks(3);
    u_if.ready = 1'b1;
    ticks(1);
    u_if.ready = 1'b0;
    ticks(3);

    // Back-to-back with ready held high.
    u_if.ready = 1'b1;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    ticks(4);
    u_if.ready = 1'b0;

    // Overrun: second byte lands on an unconsumed first one.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    ticks(4);

    // Reset in the middle of data bit 4 of 0xC3.
    b = 8'hC3;
    e0 = cyc + 1;
    busy_on[e0 + 2] = 1'b1;
    rx = 1'b0;
    ticks(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      ticks(DIV);
    end
    rx = b[4];
    ticks(HALF);
    reset_n = 1'b0;
    rx = 1'b1;
    clear_events();
    m_valid = 1'b0; m_data = 8'h00; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    #1;
    chk("rst_valid",     8'(u_if.valid),     8'h00);
    chk("rst_busy",      8'(u_if.busy),      8'h00);
    chk("rst_data",      u_if.data_out,      8'h00);
    chk("rst_frame_err", 8'(u_if.frame_err), 8'h00);
    chk("rst_overrun",   8'(u_if.overrun),   8'h00);
    ticks(4);
    reset_n = 1'b1;
    ticks(10);
    send_frame(8'h3C, 1'b1);
    ticks(3);
    u_if.ready = 1'b1;
    ticks(1);
    u_if.ready = 1'b0;
    ticks(2);

    // Framing error followed by a 40-bit break.
    send_frame(8'h7E, 1'b0);
    ticks(40 * DIV);
    release_line();
    ticks(10);

    // Short glitch on an idle line.
    glitch(4);

    // Randomised traffic with a randomly toggling consumer.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          int sel;
          sel = int'($urandom_range(0, 9));
          if (sel == 0) begin
            glitch(int'($urandom_range(1, 6)));
          end else if (sel == 1) begin
            send_frame(8'($urandom), 1'b0);
            ticks(int'($urandom_range(0, 40)));
            release_line();
            ticks(int'($urandom_range(1, 5)));
          end else begin
            send_frame(8'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) ticks(int'($urandom_range(1, 20)));
          end
        end
        ticks(20);
        done = 1'b1;
      end
      begin
        while (!done) begin
          ticks(1);
          u_if.ready = ($urandom_range(0, 3) == 0);
        end
      end
    join
    u_if.ready = 1'b0;
    ticks(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
# uart_rx_module

Receive half of the board UART link: deserialises 8N1 frames from the asynchronous `rx` pin into bytes and presents each one on a valid/ready holding register. It is the counterpart of the UART transmitter in the same FPGA and uses the same baud divisor convention. It detects false starts and framing errors, and reports overrun when the consumer is slow. It sits between the pin and the command/packet parser.

## Interface
- `CLK_DIV`, 217: clock cycles per bit (25 MHz / 115200); legal range 4..65535.
- `HALF` (localparam), `CLK_DIV/2`, integer division: mid-bit offset.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data_out`  out  8  last received byte.
- `valid`  out  1  `data_out` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data_out` in any cycle where `valid` is also high.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a new byte overwrote an unconsumed byte.

## Operation
- `rx` passes through a 2-FF synchroniser (`rx_s`), reset to 1. All decisions use `rx_s`.
- States:
  - IDLE, on `rx_s==0`: go to START and set `clk_cnt=HALF-1`.
  - START, when `clk_cnt==0`:
    - if `rx_s==0`: go to DATA, set `clk_cnt=CLK_DIV-1` and `bit_cnt=0`.
    - else: false start, return to IDLE with no output.
  - DATA, when `clk_cnt==0`: shift `rx_s` into the MSB of the shift register (shift right, LSB first on the wire), increment `bit_cnt`, reload `clk_cnt`. After the 8th sample (`bit_cnt==7`), go to STOP.
  - STOP, when `clk_cnt==0`:
    - if `rx_s==1`: load `data_out`, set `valid=1`, go to IDLE.
    - else: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line (break) produces exactly one `frame_err`.
- In every state other than IDLE/BREAK, `clk_cnt` decrements each cycle while nonzero.
- `clk_cnt` is 16 bits and `bit_cnt` is 3 bits; neither counter wraps in normal operation.
- Holding register behaviour:
  - `valid` clears on any cycle with `valid && ready`.
  - New byte and `ready` in the same cycle: the new byte loads, `valid` stays 1, no `overrun`.
  - New byte with `valid=1` and `ready=0`: the new byte overwrites `data_out` (newest wins) and `overrun` pulses.
- Reset (asynchronous, any time including mid-frame): state IDLE, counters 0, `data_out=0x00`, `valid=0`, `busy=0`, `frame_err=0`, `overrun=0`, synchroniser = 1. A partial frame is dropped. If the line is still low at reset release, it is treated as a new start bit.

## Timing
- Edge 0 is the first clock edge at which the first synchroniser FF captures `rx` low.
  - START is entered at edge 2.
  - The start bit is validated at edge 2+HALF.
  - Data bit i is sampled at edge 2+HALF+(i+1)·CLK_DIV.
  - The stop bit is sampled at edge 2+HALF+9·CLK_DIV. `valid`, `frame_err` and `overrun` update on that edge.
- `busy` rises at edge 2 and falls on the stop-sample edge (or later, on leaving BREAK).
- Back-to-back frames are supported: IDLE is reached about half a bit before the stop bit ends, so a following start edge is caught without loss.
- `ready` has no combinational path to any output. All outputs are registered.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - `UART_CLK_DIV_DEFAULT=217`;
  - `UART_DATA_BITS=8`.
  - The transmitter uses the same package.
- One natural sub-module, `sync_2ff`: a generic 2-stage synchroniser with a reset value parameter, reused for other asynchronous inputs.
- Everything else stays in a single `always_ff` block plus output assigns.

## Test plan
Bench uses CLK_DIV=16 (so HALF=8), with an ideal `rx` driver at exactly 16 cycles per bit.
- Send 0x55 with `ready=0` → `data_out=0x55`, `valid` rises at edge 154, `busy` high from edge 2 to edge 154, no error pulses. Then assert `ready` for 1 cycle → `valid=0`.
- Send 0xA3 and 0x0F back-to-back with no idle gap, `ready` held at 1 → two `valid` cycles in order (0xA3 then 0x0F), no `overrun`.
- Send 0x11 then 0x22 with `ready=0` → after the second frame, `data_out=0x22` and `overrun` pulses once.
- Send 0x7E with the stop bit forced low, then keep `rx` low for 40 bit-times → exactly one `frame_err` pulse, `valid` stays 0, `busy` stays high until `rx` returns high.
- Drive a 4-cycle low glitch on idle `rx` → START is entered, then returns to IDLE at edge 10; no `valid` and no `frame_err`.
- Assert `reset_n` low during data bit 4 of 0xC3 → all outputs return to reset values immediately. After release, send 0x3C → received correctly.
